// File: rtl/cpu_bus.sv
// CPU bus decoder: serves internal work RAM and forwards PPU/I-O/cartridge accesses over one external handshake.
// Optional external-access timeout is enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus #(
  parameter int unsigned RAM_ADDR_BITS  = 11,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_address_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_write_i,
  input  logic        cpu_valid_i,
  output logic        cpu_busy_o,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic [1:0]  ext_select_o,
  output logic [15:0] ext_address_o,
  output logic [7:0]  ext_data_o,
  output logic        ext_write_o,
  output logic        ext_valid_o,
  input  logic [7:0]  ext_data_i,
  input  logic        ext_ack_i,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] RAM_ACCESS = 2'd1;
  localparam logic [1:0] EXT_WAIT   = 2'd2;
  localparam logic [1:0] RESPOND    = 2'd3;

  localparam logic [1:0] SEL_PPU  = 2'd0;
  localparam logic [1:0] SEL_IO   = 2'd1;
  localparam logic [1:0] SEL_CART = 2'd2;

  logic [1:0]               state_r;
  logic [RAM_ADDR_BITS-1:0] ram_idx_r;
  logic [7:0]               wdata_r;
  logic                     write_r;
  logic [7:0]               open_bus_r;
  logic [7:0]               ram_r [0:(2**RAM_ADDR_BITS)-1];

  logic                     accept_s;
  logic                     is_ram_s;
  logic [1:0]               sel_s;
  logic [15:0]              ext_addr_s;
  logic [7:0]               ram_rdata_s;
  logic                     ram_we_s;
  logic                     expire_s;

  // Address decode of the incoming request, first match wins.
  always_comb begin
    is_ram_s   = 1'b0;
    sel_s      = SEL_CART;
    ext_addr_s = cpu_address_i;
    if (cpu_address_i < 16'h2000) begin
      is_ram_s = 1'b1;
    end else if (cpu_address_i < 16'h4000) begin
      sel_s      = SEL_PPU;
      ext_addr_s = {13'h0400, cpu_address_i[2:0]};
    end else if (cpu_address_i <= 16'h401F) begin
      sel_s = SEL_IO;
    end else begin
      sel_s = SEL_CART;
    end
  end

  assign accept_s    = cpu_valid_i && ((state_r == IDLE) || (state_r == RESPOND));
  assign ram_rdata_s = ram_r[ram_idx_r];
  // A write landing in the same cycle as reset is dropped.
  assign ram_we_s    = (state_r == RAM_ACCESS) && write_r && !reset_i;

`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  // Counts unacknowledged EXT_WAIT cycles; cleared whenever outside EXT_WAIT.
  always_ff @(posedge clock_i) begin
    if (reset_i || (state_r != EXT_WAIT)) begin
      wait_cnt_r <= 8'd0;
    end else if (!ext_ack_i) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // An ack on the expiry cycle wins over the timeout.
  assign expire_s = (state_r == EXT_WAIT) && !ext_ack_i &&
                    (wait_cnt_r == 8'(TIMEOUT_CYCLES - 1));
`else
  assign expire_s = 1'b0;
`endif

  // Work RAM array; never reset.
  always_ff @(posedge clock_i) begin
    if (ram_we_s) begin
      ram_r[ram_idx_r] <= wdata_r;
    end
  end

  // Transaction sequencer with registered CPU and external outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r          <= IDLE;
      ram_idx_r        <= '0;
      wdata_r          <= 8'h00;
      write_r          <= 1'b0;
      open_bus_r       <= 8'h00;
      cpu_busy_o       <= 1'b0;
      cpu_data_o       <= 8'h00;
      cpu_data_valid_o <= 1'b0;
      ext_select_o     <= 2'd0;
      ext_address_o    <= 16'h0000;
      ext_data_o       <= 8'h00;
      ext_write_o      <= 1'b0;
      ext_valid_o      <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      cpu_data_valid_o <= 1'b0;
      timeout_o        <= 1'b0;
      case (state_r)
        IDLE, RESPOND: begin
          if (accept_s) begin
            ram_idx_r  <= cpu_address_i[RAM_ADDR_BITS-1:0];
            wdata_r    <= cpu_data_i;
            write_r    <= cpu_write_i;
            cpu_busy_o <= 1'b1;
            if (is_ram_s) begin
              state_r <= RAM_ACCESS;
            end else begin
              state_r       <= EXT_WAIT;
              ext_valid_o   <= 1'b1;
              ext_select_o  <= sel_s;
              ext_address_o <= ext_addr_s;
              ext_data_o    <= cpu_data_i;
              ext_write_o   <= cpu_write_i;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RAM_ACCESS: begin
          cpu_data_o       <= write_r ? wdata_r : ram_rdata_s;
          open_bus_r       <= write_r ? wdata_r : ram_rdata_s;
          cpu_data_valid_o <= 1'b1;
          cpu_busy_o       <= 1'b0;
          state_r          <= RESPOND;
        end
        EXT_WAIT: begin
          if (ext_ack_i || expire_s) begin
            ext_valid_o      <= 1'b0;
            ext_select_o     <= 2'd0;
            ext_address_o    <= 16'h0000;
            ext_data_o       <= 8'h00;
            ext_write_o      <= 1'b0;
            cpu_data_valid_o <= 1'b1;
            cpu_busy_o       <= 1'b0;
            state_r          <= RESPOND;
            if (ext_ack_i) begin
              cpu_data_o <= write_r ? wdata_r : ext_data_i;
              open_bus_r <= write_r ? wdata_r : ext_data_i;
            end else begin
              cpu_data_o <= open_bus_r;
              timeout_o  <= 1'b1;
            end
          end else begin
            state_r <= EXT_WAIT;
          end
        end
        default: begin
          state_r    <= IDLE;
          cpu_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus.sv
// Scoreboard bench for cpu_bus: stimulus pushes expected completions, a negedge monitor pops and compares them.
module tb_cpu_bus;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 16;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] cpu_address_i = 16'h0000;
  logic [7:0]  cpu_data_i = 8'h00;
  logic        cpu_write_i = 1'b0;
  logic        cpu_valid_i = 1'b0;
  logic        cpu_busy_o;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic [1:0]  ext_select_o;
  logic [15:0] ext_address_o;
  logic [7:0]  ext_data_o;
  logic        ext_write_o;
  logic        ext_valid_o;
  logic [7:0]  ext_data_i = 8'h00;
  logic        ext_ack_i = 1'b0;
  logic        timeout_o;

  cpu_bus #(.RAM_ADDR_BITS(11), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i),
    .cpu_write_i(cpu_write_i), .cpu_valid_i(cpu_valid_i),
    .cpu_busy_o(cpu_busy_o), .cpu_data_o(cpu_data_o),
    .cpu_data_valid_o(cpu_data_valid_o),
    .ext_select_o(ext_select_o), .ext_address_o(ext_address_o),
    .ext_data_o(ext_data_o), .ext_write_o(ext_write_o),
    .ext_valid_o(ext_valid_o), .ext_data_i(ext_data_i),
    .ext_ack_i(ext_ack_i), .timeout_o(timeout_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [7:0] data;
    bit         chk_data;
    int         cyc;
    bit         to;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clock_i) begin
    if (!reset_i && cpu_data_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'(cpu_data_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) check("cpu_data_o", 32'(cpu_data_o), 32'(e.data));
        check("completion_cycle", 32'(cyc), 32'(e.cyc));
        check("timeout_o", 32'(timeout_o), 32'(e.to));
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit chk, input int c, input bit to);
    exp_t e;
    e.data = d; e.chk_data = chk; e.cyc = c; e.to = to;
    sb.push_back(e);
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic w, output int t);
    int n;
    n = 0;
    while (cpu_busy_o && n < 50) begin
      @(posedge clock_i); #1; n++;
    end
    check("idle_before_issue", 32'(cpu_busy_o), 32'd0);
    cpu_address_i = a; cpu_data_i = d; cpu_write_i = w; cpu_valid_i = 1'b1;
    t = cyc;
    @(posedge clock_i); #1;
    cpu_valid_i = 1'b0; cpu_write_i = 1'b0;
    check("busy_after_accept", 32'(cpu_busy_o), 32'd1);
  endtask

  task automatic ram_op(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic [7:0] exp, input bit chk);
    int t;
    issue(a, d, w, t);
    push(exp, chk, t + 2, 1'b0);
  endtask

  task automatic ext_txn(input logic [15:0] a, input logic [7:0] d, input logic w,
                         input logic [1:0] sel, input logic [15:0] xaddr,
                         input int delay, input logic [7:0] rdata, input bit poke);
    int t;
    issue(a, d, w, t);
    check("ext_valid_o", 32'(ext_valid_o), 32'd1);
    check("ext_select_o", 32'(ext_select_o), 32'(sel));
    check("ext_address_o", 32'(ext_address_o), 32'(xaddr));
    check("ext_write_o", 32'(ext_write_o), 32'(w));
    if (w) check("ext_data_o", 32'(ext_data_o), 32'(d));
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        cpu_address_i = 16'h0005; cpu_data_i = 8'hEE; cpu_write_i = 1'b1; cpu_valid_i = 1'b1;
      end
      @(posedge clock_i); #1;
      cpu_valid_i = 1'b0; cpu_write_i = 1'b0;
      check("ext_valid_hold", 32'(ext_valid_o), 32'd1);
      check("ext_data_hold", 32'(ext_data_o), 32'(d));
      check("ext_address_hold", 32'(ext_address_o), 32'(xaddr));
    end
    ext_ack_i = 1'b1; ext_data_i = rdata;
    push(w ? d : rdata, 1'b1, cyc + 1, 1'b0);
    @(posedge clock_i); #1;
    ext_ack_i = 1'b0;
    check("ext_valid_drop", 32'(ext_valid_o), 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clock_i);
    #1;
    check("rst_busy", 32'(cpu_busy_o), 32'd0);
    check("rst_data", 32'(cpu_data_o), 32'd0);
    check("rst_valid", 32'(cpu_data_valid_o), 32'd0);
    check("rst_ext_valid", 32'(ext_valid_o), 32'd0);
    check("rst_ext_addr", 32'(ext_address_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clock_i); #1;

    // RAM mirroring, issued back to back (each accepted in the RESPOND cycle)
    ram_op(16'h0005, 8'hA5, 1'b1, 8'hA5, 1'b1);
    ram_op(16'h0805, 8'h00, 1'b0, 8'hA5, 1'b1);
    ram_op(16'h1005, 8'h00, 1'b0, 8'hA5, 1'b1);
    ram_op(16'h1805, 8'h00, 1'b0, 8'hA5, 1'b1);

    // PPU mirror read with a request poked while busy
    ext_txn(16'h3FFA, 8'h00, 1'b0, 2'd0, 16'h2002, 3, 8'h42, 1'b1);
    ram_op(16'h0005, 8'h00, 1'b0, 8'hA5, 1'b1);

    // Cartridge write echoes write data, I/O and boundary decodes
    ext_txn(16'h8000, 8'h7E, 1'b1, 2'd2, 16'h8000, 2, 8'h99, 1'b0);
    ext_txn(16'h4016, 8'h00, 1'b0, 2'd1, 16'h4016, 0, 8'h5A, 1'b0);
    ext_txn(16'h401F, 8'h00, 1'b0, 2'd1, 16'h401F, 1, 8'hC3, 1'b0);
    ext_txn(16'h4020, 8'h00, 1'b0, 2'd2, 16'h4020, 1, 8'h3C, 1'b0);
    ext_txn(16'h2000, 8'h00, 1'b0, 2'd0, 16'h2000, 1, 8'h81, 1'b0);

    // Stray ack while idle must produce nothing
    @(posedge clock_i); #1;
    ext_ack_i = 1'b1; ext_data_i = 8'hDD;
    @(posedge clock_i); #1;
    ext_ack_i = 1'b0;
    check("stray_ack_busy", 32'(cpu_busy_o), 32'd0);

    // Reset coinciding with a RAM write's access cycle drops the write
    ram_op(16'h0010, 8'h11, 1'b1, 8'h11, 1'b1);
    issue(16'h0010, 8'h77, 1'b1, t);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    check("rst_ram_busy", 32'(cpu_busy_o), 32'd0);
    check("rst_ram_data", 32'(cpu_data_o), 32'd0);
    ram_op(16'h0010, 8'h00, 1'b0, 8'h11, 1'b1);

    // Reset during an external wait
    issue(16'h2001, 8'h00, 1'b0, t);
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    check("rst_ext_valid_mid", 32'(ext_valid_o), 32'd0);
    check("rst_ext_busy_mid", 32'(cpu_busy_o), 32'd0);
    ram_op(16'h0123, 8'h00, 1'b0, 8'h00, 1'b0);

`ifdef CPU_BUS_TIMEOUT_EN
    // Timeout returns open-bus value; ack on the expiry cycle wins
    ram_op(16'h0000, 8'h33, 1'b1, 8'h33, 1'b1);
    issue(16'h4016, 8'h00, 1'b0, t);
    push(8'h33, 1'b1, t + 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_i); #1;
      check("to_valid_hold", 32'(ext_valid_o), 32'd1);
    end
    @(posedge clock_i); #1;
    check("to_valid_drop", 32'(ext_valid_o), 32'd0);
    check("to_pulse", 32'(timeout_o), 32'd1);
    ext_txn(16'h4016, 8'h00, 1'b0, 2'd1, 16'h4016, 3, 8'h6B, 1'b0);
`endif

    repeat (5) @(posedge clock_i);
    #1;
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus.md
Name: cpu_bus

Overview:
- Downstream stage of the CPU core: accepts one CPU bus request at a time and decodes the 16-bit address into the console memory map.
- Serves internal 2 KiB work RAM directly.
- Forwards PPU-register, I/O and cartridge accesses over one shared external handshake port.
- Returns read data, or a write acknowledge, to the CPU as a one-cycle valid pulse; unanswered external accesses return the open-bus value.

Parameters:
- RAM_ADDR_BITS, 11, work RAM depth is 2**RAM_ADDR_BITS bytes; 11 gives 2 KiB.
- TIMEOUT_CYCLES, 16, maximum cycles ext_valid_o stays asserted without ext_ack_i before timeout; legal range 1..255.

Ports:
- clock_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- cpu_address_i  input  16  request address
- cpu_data_i  input  8  write data
- cpu_write_i  input  1  1 = write, 0 = read
- cpu_valid_i  input  1  request strobe, sampled only when cpu_busy_o = 0
- cpu_busy_o  output  1  request in flight; new requests ignored
- cpu_data_o  output  8  read data, or echoed write data
- cpu_data_valid_o  output  1  one-cycle completion pulse
- ext_select_o  output  2  target: 0 PPU, 1 I/O, 2 cartridge
- ext_address_o  output  16  target address
- ext_data_o  output  8  write data
- ext_write_o  output  1  write flag
- ext_valid_o  output  1  request held until ack or timeout
- ext_data_i  input  8  target read data, sampled with ext_ack_i
- ext_ack_i  input  1  target completion
- timeout_o  output  1  one-cycle pulse on external timeout

Behaviour:
- Reset values: cpu_busy_o=0, cpu_data_o=0, cpu_data_valid_o=0, ext_*_o=0, timeout_o=0, open-bus register=0x00, state IDLE. RAM contents are not cleared.
- Address decode, first match wins:
  - 0x0000-0x1FFF: RAM, index = address[RAM_ADDR_BITS-1:0] (mirrored).
  - 0x2000-0x3FFF: PPU, ext_address_o = 0x2000 | address[2:0].
  - 0x4000-0x401F: I/O, full address.
  - 0x4020-0xFFFF: cartridge, full address.
- States: IDLE, RAM_ACCESS, EXT_WAIT, RESPOND.
- IDLE:
  - cpu_valid_i high in cycle T → latch address, data and write flag; cpu_busy_o=1 from T+1.
  - Go to RAM_ACCESS or EXT_WAIT per decode.
- RAM_ACCESS (cycle T+1):
  - Write updates the array at the end of T+1.
  - Read registers the array word.
  - Next state RESPOND.
- EXT_WAIT:
  - ext_valid_o=1 from T+1 with select, address, data and write stable until exit.
  - ext_ack_i high in cycle A → capture ext_data_i (reads); ext_valid_o=0 from A+1; go to RESPOND.
- RESPOND:
  - cpu_data_valid_o=1 for exactly one cycle.
  - cpu_data_o = read data, or latched write data for writes.
  - Then IDLE with cpu_busy_o=0 in the same cycle, so a new request can be accepted immediately.
- Latency:
  - RAM: cpu_data_valid_o in cycle T+2.
  - External: cpu_data_valid_o in cycle A+1.
  - cpu_data_o holds its value until the next completion.
- Open bus:
  - Register updated with every completed transfer: write data, read data, or RAM read data.
  - Not updated by a timeout.
- ext_ack_i while ext_valid_o=0 is ignored. ext_ack_i in the same cycle as the timeout expiry counts as an ack; no timeout.
- cpu_valid_i while busy is ignored: no queueing, no error.
- reset_i mid-transaction:
  - Abort next cycle; all outputs return to reset values.
  - A RAM write whose RAM_ACCESS cycle coincides with reset is not performed.

Optional Feature:
- Macro CPU_BUS_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entering EXT_WAIT and increments each EXT_WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: ext_valid_o drops next cycle, timeout_o pulses one cycle, and RESPOND returns the open-bus value.
- Undefined:
  - No counter; EXT_WAIT waits indefinitely for ext_ack_i.
  - timeout_o tied to 0.

Test Plan:
- RAM mirroring: write 0xA5 to 0x0005; read 0x0805, 0x1005 and 0x1805 → each read returns 0xA5 with cpu_data_valid_o exactly 2 cycles after acceptance.
- PPU mirror: read 0x3FFA; target acks 3 cycles after ext_valid_o with data 0x42 → ext_select_o=0, ext_address_o=0x2002, cpu_data_o=0x42 one cycle after ack.
- Cartridge write: write 0x7E to 0x8000 → ext_select_o=2, ext_write_o=1, ext_data_o=0x7E held until ack; completion echoes 0x7E.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - Write 0x33 to 0x0000, then read 0x4016 with no ack.
  - Response: timeout_o pulses, ext_valid_o drops, cpu_data_o=0x33.
  - Repeat with ack landing on the expiry cycle → no timeout; ack data returned.
- Busy/back-to-back: assert cpu_valid_i during an external wait → ignored; a request issued in the RESPOND cycle is accepted.
- Reset mid-operation: reset during EXT_WAIT → ext_valid_o=0 and cpu_busy_o=0 next cycle; a following RAM read of an untouched address completes normally.
